imm_gen_pipe: RTL

- Parametrised, pipelined successor to the combinational immediate generator.
- Extracts and sign- or zero-extends the RV immediate to XLEN bits and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer absorbs downstream stalls; a tag travels alongside each result.
- Sits between fetch/decode and the ALU-operand mux; adds CSR zimm support, RV64 shamt, flush and an illegal-select flag.

---
 rtl/imm_gen_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined RV immediate generator with valid/ready handshake,
//            2-entry skid buffer, tag sideband and flush. Optional macro
//            IMM_SEL_AUTO_EN decodes the format from the opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [31:0]      Inst,
   input  logic [2:0]       ImmSel,
   input  logic [TAG_W-1:0] InTag,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [XLEN-1:0]  DataOut,
   output logic [TAG_W-1:0] OutTag,
   output logic             IllegalSel
);

   localparam logic [2:0] C_SEL_I     = 3'b000;
   localparam logic [2:0] C_SEL_IU    = 3'b001;
   localparam logic [2:0] C_SEL_SHAMT = 3'b010;
   localparam logic [2:0] C_SEL_S     = 3'b011;
   localparam logic [2:0] C_SEL_B     = 3'b100;
   localparam logic [2:0] C_SEL_U     = 3'b101;
   localparam logic [2:0] C_SEL_J     = 3'b110;
   localparam logic [2:0] C_SEL_Z     = 3'b111;

   localparam logic [1:0] C_ST_EMPTY  = 2'd0;
   localparam logic [1:0] C_ST_ONE    = 2'd1;
   localparam logic [1:0] C_ST_FULL   = 2'd2;

   logic [2:0]       w_sel;
   logic             w_illegal;
   logic [XLEN-1:0]  w_imm;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             w_accept;
   logic             w_drain;
   logic             w_load_new;
   logic             w_load_skid;
   logic             w_refill;

   logic [XLEN-1:0]  r_out_data;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_out_ill;
   logic [XLEN-1:0]  r_skid_data;
   logic [TAG_W-1:0] r_skid_tag;
   logic             r_skid_ill;

`ifdef IMM_SEL_AUTO_EN
   logic [2:0] w_unused_sel;
   assign w_unused_sel = ImmSel;

   always_comb begin
      w_sel     = C_SEL_I;
      w_illegal = 1'b0;
      case (Inst[6:0])
         7'b0010011: w_sel = (Inst[13:12] == 2'b01) ? C_SEL_SHAMT : C_SEL_I;
         7'b0000011,
         7'b1100111: w_sel = C_SEL_I;
         7'b0100011: w_sel = C_SEL_S;
         7'b1100011: w_sel = C_SEL_B;
         7'b0110111,
         7'b0010111: w_sel = C_SEL_U;
         7'b1101111: w_sel = C_SEL_J;
         7'b1110011: begin
            if (Inst[14]) w_sel = C_SEL_Z;
            else          w_illegal = 1'b1;
         end
         default:    w_illegal = 1'b1;
      endcase
   end
`else
   logic [6:0] w_unused_opcode;
   assign w_unused_opcode = Inst[6:0];
   assign w_sel           = ImmSel;
   assign w_illegal       = 1'b0;
`endif

   // Size casts of signed operands sign-extend; unsigned ones zero-extend.
   always_comb begin
      w_imm = '0;
      case (w_sel)
         C_SEL_I:     w_imm = XLEN'($signed(Inst[31:20]));
         C_SEL_IU:    w_imm = XLEN'(Inst[31:20]);
         C_SEL_SHAMT: w_imm = (XLEN == 64) ? XLEN'(Inst[25:20]) : XLEN'(Inst[24:20]);
         C_SEL_S:     w_imm = XLEN'($signed({Inst[31:25], Inst[11:7]}));
         C_SEL_B:     w_imm = XLEN'($signed({Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0}));
         C_SEL_U:     w_imm = XLEN'($signed({Inst[31:12], 12'b0}));
         C_SEL_J:     w_imm = XLEN'($signed({Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0}));
         C_SEL_Z:     w_imm = XLEN'(Inst[19:15]);
         default:     w_imm = '0;
      endcase
      if (w_illegal) w_imm = '0;
   end

   assign w_accept    = InValid && InReady;
   assign w_drain     = OutValid && OutReady;
   assign w_load_new  = w_accept && ((r_state == C_ST_EMPTY) || w_drain);
   assign w_load_skid = w_accept && (r_state == C_ST_ONE) && !w_drain;
   assign w_refill    = w_drain && (r_state == C_ST_FULL);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= C_ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_EMPTY: if (w_accept) w_state_nxt = C_ST_ONE;
         C_ST_ONE: begin
            if (w_accept && !w_drain)      w_state_nxt = C_ST_FULL;
            else if (!w_accept && w_drain) w_state_nxt = C_ST_EMPTY;
         end
         C_ST_FULL:  if (w_drain) w_state_nxt = C_ST_ONE;
         default:    w_state_nxt = C_ST_EMPTY;
      endcase
      if (Flush) w_state_nxt = C_ST_EMPTY;
   end

   // Handshake flags decode only the state register, so InReady has no path from OutReady.
   always_comb begin
      OutValid = (r_state == C_ST_ONE) || (r_state == C_ST_FULL);
      InReady  = (r_state != C_ST_FULL);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_out_data  <= '0;
         r_out_tag   <= '0;
         r_out_ill   <= 1'b0;
         r_skid_data <= '0;
         r_skid_tag  <= '0;
         r_skid_ill  <= 1'b0;
      end else if (!Flush) begin
         if (w_load_new) begin
            r_out_data <= w_imm;
            r_out_tag  <= InTag;
            r_out_ill  <= w_illegal;
         end else if (w_refill) begin
            r_out_data <= r_skid_data;
            r_out_tag  <= r_skid_tag;
            r_out_ill  <= r_skid_ill;
         end
         if (w_load_skid) begin
            r_skid_data <= w_imm;
            r_skid_tag  <= InTag;
            r_skid_ill  <= w_illegal;
         end
      end
   end

   assign DataOut    = r_out_data;
   assign OutTag     = r_out_tag;
   assign IllegalSel = r_out_ill;

endmodule

`default_nettype wire
